// File: rtl/seq_scan_ctrl.sv
// Serialises a captured word LSB-first into an external Mealy detector and reports the match count, the first match position and a done pulse.
// Optional SEQ_SCAN_ABORT_EN adds an abort input that ends a scan early and an aborted status flag.
module seq_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LEN_W-1:0]  bit_len,
    output logic              det_x,
    output logic              det_rst,
    input  logic              det_y,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  first_pos,
    output logic              found
`ifdef SEQ_SCAN_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  sreg, sreg_n;
    logic [LEN_W-1:0]   k, k_n;
    logic [LEN_W-1:0]   len, len_n;
    logic [LEN_W-1:0]   len_clamp;
    logic               det_x_n, det_rst_n, busy_n, done_n, found_n;
    logic [CNT_W-1:0]   cnt_n, first_n;
    logic               abort_req;
    logic               aborted_q, aborted_n;

`ifdef SEQ_SCAN_ABORT_EN
    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    assign len_clamp = (bit_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bit_len;

    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        k_n       = k;
        len_n     = len;
        det_x_n   = det_x;
        det_rst_n = det_rst;
        busy_n    = busy;
        done_n    = 1'b0;
        cnt_n     = match_cnt;
        first_n   = first_pos;
        found_n   = found;
        aborted_n = aborted_q;
        case (state)
            IDLE: begin
                det_rst_n = 1'b1;
                det_x_n   = 1'b0;
                busy_n    = 1'b0;
                if (start) begin
                    len_n     = len_clamp;
                    sreg_n    = data_in >> 1;
                    k_n       = '0;
                    cnt_n     = '0;
                    first_n   = '0;
                    found_n   = 1'b0;
                    aborted_n = 1'b0;
                    busy_n    = 1'b1;
                    if (len_clamp == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = SHIFT;
                        det_rst_n = 1'b0;
                        det_x_n   = data_in[0];
                    end
                end
            end
            SHIFT: begin
                if (det_y) begin
                    if (match_cnt != '1)
                        cnt_n = match_cnt + CNT_W'(1);
                    if (!found) begin
                        first_n = CNT_W'(k);
                        found_n = 1'b1;
                    end
                end
                // The detector's y for this bit is taken even on an aborted cycle.
                if (k == len - LEN_W'(1) || abort_req) begin
                    state_n   = DONE;
                    done_n    = 1'b1;
                    det_rst_n = 1'b1;
                    det_x_n   = 1'b0;
                    aborted_n = abort_req;
                end else begin
                    det_x_n = sreg[0];
                    sreg_n  = sreg >> 1;
                    k_n     = k + LEN_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            k         <= '0;
            len       <= '0;
            det_x     <= 1'b0;
            det_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            match_cnt <= '0;
            first_pos <= '0;
            found     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            k         <= k_n;
            len       <= len_n;
            det_x     <= det_x_n;
            det_rst   <= det_rst_n;
            busy      <= busy_n;
            done      <= done_n;
            match_cnt <= cnt_n;
            first_pos <= first_n;
            found     <= found_n;
            aborted_q <= aborted_n;
        end
    end

endmodule
